alink_tx_sched: RTL
===================

# alink_tx_sched

Round-robin transmit scheduler for the alink block. It arbitrates among CH_NUM miner channels with pending tasks and launches one transmission at a time on the shared serializer. After each transmission it sequences the shared tx_timer and waits for either a matching response or a timeout before it grants the link again. It sits between the per-channel task FIFOs and the serializer/tx_timer pair.

## Interface
- CH_NUM, 4: number of requesting channels (2..16)
- CH_W, 2: channel index width, equal to clog2(CH_NUM)
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- reg_enable  in  1  permits new grants; an in-flight transaction always completes
- reg_flush  in  1  synchronous abort to IDLE; clears tout_cnt
- task_req  in  CH_NUM  level, one bit per channel: task pending
- task_ack  out  CH_NUM  one-cycle pulse on the granted channel's bit
- tx_start  out  1  one-cycle pulse that starts the serializer
- tx_ch  out  CH_W  granted channel; held stable from tx_start until return to IDLE
- tx_done  in  1  serializer finished pulse
- timer_start  out  1  one-cycle pulse to tx_timer
- timer_done  in  1  tx_timer expiry
- rx_valid  in  1  response received pulse
- rx_ch  in  CH_W  channel of the response
- tout_pulse  out  1  one-cycle timeout indication
- tout_ch  out  CH_W  channel that timed out; valid with tout_pulse, held until the next timeout
- tout_cnt  out  32  timeout counter, saturating at 32'hFFFF_FFFF
- busy  out  1  high when state is not IDLE

## Operation
- States: IDLE, SEND, WAIT. The encoding is free.
- IDLE: if reg_enable and |task_req, pick a winner and go to SEND. On entry to SEND, task_ack[winner], tx_start and tx_ch=winner are registered.
- Arbitration: search starts at last+1 and wraps modulo CH_NUM. The first set task_req bit wins. last <= winner on grant.
- SEND: wait for tx_done. On tx_done, go to WAIT and register timer_start=1 for one cycle. Other inputs are ignored.
- WAIT:
  - rx_valid with rx_ch==tx_ch: go to IDLE (success).
  - Otherwise, timer_done with timer_start low: go to IDLE. Register tout_pulse=1 and tout_ch=tx_ch, and increment tout_cnt.
  - rx_valid with a non-matching rx_ch is ignored.
- Simultaneous matching rx_valid and timer_done in WAIT: the response wins. No timeout is recorded.
- timer_done is ignored in the cycle in which timer_start is high, which guards against a stale expiry.
- reg_tout=0 in the timer means timer_done never fires. WAIT is then left only by a matching response or by reg_flush.
- reg_flush, in any state: next state IDLE. Clears tout_cnt. Suppresses all pulses in the following cycle. last is unchanged.
- If reg_flush and a transition condition occur in the same cycle, flush wins.
- Deasserting reg_enable mid-transaction does not abort. No grant is made while it is low.
- tout_cnt saturates and does not wrap.

## Timing
- Reset values:
  - state IDLE
  - last = CH_NUM-1, so ch0 wins first
  - task_ack=0, tx_start=0, tx_ch=0, timer_start=0
  - tout_pulse=0, tout_ch=0, tout_cnt=0, busy=0
- Grant latency: task_req sampled high in IDLE at edge N gives task_ack, tx_start and busy high in cycle N+1.
- tx_done sampled at edge M gives timer_start high in cycle M+1.
- Response or timeout sampled at edge K: state is IDLE in cycle K+1, and tout_pulse (if any) is also high in K+1. The earliest next tx_start is K+2.
- All outputs are registered. There are no combinational input-to-output paths.
- task_req may drop after task_ack. The scheduler does not re-sample it until the next IDLE.

## Test plan
- Reset, then task_req=4'b0101 with tx_done 3 cycles after tx_start and a matching rx_valid 10 cycles later. Required: ch0 granted first, then ch2. One task_ack pulse each. tout_cnt=0.
- All four requests held high continuously. Required: grant order 0,1,2,3,0. tx_ch is stable during each transaction.
- Timer model with reg_tout=20 and no response. Required: tout_pulse 1 cycle after timer_done, tout_ch=granted channel, tout_cnt=1, return to IDLE.
- In WAIT, rx_valid with a wrong rx_ch: no exit. Then rx_valid and timer_done in the same cycle with a matching rx_ch: success, no tout_pulse, tout_cnt unchanged.
- reg_flush asserted in SEND and again in WAIT. Required: IDLE next cycle, no pulses that cycle, tout_cnt=0, the next grant continues from last+1.
- Async rst asserted mid-WAIT between clock edges. Required: all outputs at reset values immediately. tout_cnt forced to 32'hFFFF_FFFE plus 2 timeouts holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/alink_tx_sched_if.sv
// Scheduler-side bundle: per-channel task handshake, serializer/timer sequencing and
// the timeout reporting outputs.
interface alink_tx_sched_if #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned CH_W   = 2
);
    logic              reg_enable;
    logic              reg_flush;
    logic [CH_NUM-1:0] task_req;
    logic [CH_NUM-1:0] task_ack;
    logic              tx_start;
    logic [CH_W-1:0]   tx_ch;
    logic              tx_done;
    logic              timer_start;
    logic              timer_done;
    logic              rx_valid;
    logic [CH_W-1:0]   rx_ch;
    logic              tout_pulse;
    logic [CH_W-1:0]   tout_ch;
    logic [31:0]       tout_cnt;
    logic              busy;

    modport master (
        output reg_enable, reg_flush, task_req, tx_done, timer_done, rx_valid, rx_ch,
        input  task_ack, tx_start, tx_ch, timer_start, tout_pulse, tout_ch, tout_cnt, busy
    );

    modport slave (
        input  reg_enable, reg_flush, task_req, tx_done, timer_done, rx_valid, rx_ch,
        output task_ack, tx_start, tx_ch, timer_start, tout_pulse, tout_ch, tout_cnt, busy
    );
endinterface

// File: rtl/alink_tx_sched.sv
// Round-robin transmit scheduler: grants one channel at a time, sequences the serializer
// and tx_timer, then waits for a matching response or a timeout before granting again.
module alink_tx_sched #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned CH_W   = 2
) (
    input logic              clk,
    input logic              rst,
    alink_tx_sched_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

    state_e            r_state,       w_state;
    logic [CH_W-1:0]   r_last,        w_last;
    logic [CH_NUM-1:0] r_task_ack,    w_task_ack;
    logic              r_tx_start,    w_tx_start;
    logic [CH_W-1:0]   r_tx_ch,       w_tx_ch;
    logic              r_timer_start, w_timer_start;
    logic              r_tout_pulse,  w_tout_pulse;
    logic [CH_W-1:0]   r_tout_ch,     w_tout_ch;
    logic [31:0]       r_tout_cnt,    w_tout_cnt;

    logic [CH_W-1:0]   w_win;
    logic              w_found;

    // Search last+1 .. last+CH_NUM modulo CH_NUM; first pending request wins.
    always_comb begin
        logic [CH_W:0] v_idx;
        w_win   = r_last;
        w_found = 1'b0;
        v_idx   = '0;
        for (int i = 1; i <= int'(CH_NUM); i++) begin
            v_idx = {1'b0, r_last} + (CH_W+1)'(i);
            if (v_idx >= (CH_W+1)'(CH_NUM)) begin
                v_idx = v_idx - (CH_W+1)'(CH_NUM);
            end
            if (!w_found && bus.task_req[v_idx[CH_W-1:0]]) begin
                w_win   = v_idx[CH_W-1:0];
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state       = r_state;
        w_last        = r_last;
        w_task_ack    = '0;
        w_tx_start    = 1'b0;
        w_tx_ch       = r_tx_ch;
        w_timer_start = 1'b0;
        w_tout_pulse  = 1'b0;
        w_tout_ch     = r_tout_ch;
        w_tout_cnt    = r_tout_cnt;

        unique case (r_state)
            StIdle: begin
                if (bus.reg_enable && w_found) begin
                    w_state           = StSend;
                    w_task_ack[w_win] = 1'b1;
                    w_tx_start        = 1'b1;
                    w_tx_ch           = w_win;
                    w_last            = w_win;
                end
            end
            StSend: begin
                if (bus.tx_done) begin
                    w_state       = StWait;
                    w_timer_start = 1'b1;
                end
            end
            StWait: begin
                // A matching response beats a same-cycle expiry; expiry is stale while
                // timer_start is still high.
                if (bus.rx_valid && (bus.rx_ch == r_tx_ch)) begin
                    w_state = StIdle;
                end else if (bus.timer_done && !r_timer_start) begin
                    w_state      = StIdle;
                    w_tout_pulse = 1'b1;
                    w_tout_ch    = r_tx_ch;
                    w_tout_cnt   = (r_tout_cnt == 32'hFFFF_FFFF) ? r_tout_cnt
                                                                 : r_tout_cnt + 32'd1;
                end
            end
            default: w_state = StIdle;
        endcase

        if (bus.reg_flush) begin
            w_state       = StIdle;
            w_last        = r_last;
            w_task_ack    = '0;
            w_tx_start    = 1'b0;
            w_tx_ch       = r_tx_ch;
            w_timer_start = 1'b0;
            w_tout_pulse  = 1'b0;
            w_tout_ch     = r_tout_ch;
            w_tout_cnt    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_last        <= CH_W'(CH_NUM - 1);
            r_task_ack    <= '0;
            r_tx_start    <= 1'b0;
            r_tx_ch       <= '0;
            r_timer_start <= 1'b0;
            r_tout_pulse  <= 1'b0;
            r_tout_ch     <= '0;
            r_tout_cnt    <= '0;
        end else begin
            r_state       <= w_state;
            r_last        <= w_last;
            r_task_ack    <= w_task_ack;
            r_tx_start    <= w_tx_start;
            r_tx_ch       <= w_tx_ch;
            r_timer_start <= w_timer_start;
            r_tout_pulse  <= w_tout_pulse;
            r_tout_ch     <= w_tout_ch;
            r_tout_cnt    <= w_tout_cnt;
        end
    end

    assign bus.task_ack    = r_task_ack;
    assign bus.tx_start    = r_tx_start;
    assign bus.tx_ch       = r_tx_ch;
    assign bus.timer_start = r_timer_start;
    assign bus.tout_pulse  = r_tout_pulse;
    assign bus.tout_ch     = r_tout_ch;
    assign bus.tout_cnt    = r_tout_cnt;
    assign bus.busy        = (r_state != StIdle);
endmodule
